// File: rtl/tc_ram_copier.sv
// tc_ram_copier: bus master for the 8-bit load/save RAM.
// It performs a block copy (src -> dst) or a block fill (fill_value -> dst) of len bytes.
// Addresses wrap modulo 256.
//
// Handshake with the control unit:
//   - start is sampled on posedge only while idle.
//   - busy is high from the cycle after an accepted start through the last WRITE.
//   - done pulses for one cycle after the last WRITE, or one cycle after start when len=0.
//
// RAM protocol, one byte of copy:
//   - READ: assert load.
//   - CAPTURE: the RAM drives rdata, which is registered at the closing edge.
//   - WRITE: assert save. address and data are held for the whole cycle so the RAM's
//     negedge write sees stable values.
//
// Every RAM-facing output is a flop. The next value of each one is chosen together with
// the next state.
module tc_ram_copier (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [7:0] len,
    input  logic [7:0] fill_value,
    output logic       mem_load,
    output logic       mem_save,
    output logic [7:0] mem_address,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t     state, state_n;
    logic [7:0] i, i_n, i_inc;
    logic [7:0] data_reg, data_n;
    logic [7:0] addr_n;
    logic       load_n, save_n, busy_n, done_n;

    // Operands latched on an accepted start
    logic       mode_r;
    logic [7:0] src_r, dst_r, len_r;

    assign i_inc     = i + 8'd1;
    assign mem_wdata = data_reg;

    // Next state and next registered outputs; defaults keep address/data and drop strobes
    always_comb begin
        state_n = state;
        i_n     = i;
        data_n  = data_reg;
        addr_n  = mem_address;
        load_n  = 1'b0;
        save_n  = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    i_n = 8'd0;
                    if (len == 8'd0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else if (mode) begin
                        state_n = WRITE;
                        save_n  = 1'b1;
                        addr_n  = dst;
                        data_n  = fill_value;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = READ;
                        load_n  = 1'b1;
                        addr_n  = src;
                        busy_n  = 1'b1;
                    end
                end
            end
            READ: begin
                state_n = CAPTURE;
                busy_n  = 1'b1;
            end
            CAPTURE: begin
                // RAM is driving the byte now; register it as the write data
                state_n = WRITE;
                save_n  = 1'b1;
                addr_n  = dst_r + i;
                data_n  = mem_rdata;
                busy_n  = 1'b1;
            end
            WRITE: begin
                i_n = i_inc;
                if (i_inc == len_r) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else if (mode_r) begin
                    state_n = WRITE;
                    save_n  = 1'b1;
                    addr_n  = dst_r + i_inc;
                    busy_n  = 1'b1;
                end else begin
                    state_n = READ;
                    load_n  = 1'b1;
                    addr_n  = src_r + i_inc;
                    busy_n  = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, index, data and output registers; reset aborts any transfer at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            i           <= 8'd0;
            data_reg    <= 8'd0;
            mem_address <= 8'd0;
            mem_load    <= 1'b0;
            mem_save    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            i           <= i_n;
            data_reg    <= data_n;
            mem_address <= addr_n;
            mem_load    <= load_n;
            mem_save    <= save_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    // Operand latch; only an accepted start in IDLE updates it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= 1'b0;
            src_r  <= 8'd0;
            dst_r  <= 8'd0;
            len_r  <= 8'd0;
        end else if (state == IDLE && start) begin
            mode_r <= mode;
            src_r  <= src;
            dst_r  <= dst;
            len_r  <= len;
        end
    end

endmodule

// File: tb/tb_tc_ram_copier.sv
// Bench for tc_ram_copier: a behavioural RAM, a reference memory image and an
// expected-write queue built from the copy/fill rules, plus directed and random operations.
module tb_tc_ram_copier;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] src, dst, len, fill_value;
    logic       mem_load, mem_save;
    logic [7:0] mem_address, mem_wdata, mem_rdata;
    logic       busy, done;

    logic [7:0]  mem     [256];
    logic [7:0]  exp_mem [256];
    logic [15:0] exp_q[$];
    logic        rd_en;
    logic [7:0]  rd_addr;
    int          n_checks;
    int          n_errors;
    int          excl_viol;

    tc_ram_copier dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .src         (src),
        .dst         (dst),
        .len         (len),
        .fill_value  (fill_value),
        .mem_load    (mem_load),
        .mem_save    (mem_save),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .done        (done)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // RAM model: load sampled on posedge, byte driven during the following cycle
    always @(posedge clk) begin
        rd_en   <= mem_load;
        rd_addr <= mem_address;
    end
    assign mem_rdata = rd_en ? mem[rd_addr] : 8'd0;

    // RAM write on negedge and scoreboard of every write the DUT issues
    always @(negedge clk) begin
        if (mem_load && mem_save) excl_viol++;
        if (mem_save) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {mem_address, mem_wdata}, 32'hFFFF_FFFF);
            end else begin
                check("write_addr_data", {mem_address, mem_wdata}, exp_q.pop_front());
            end
            mem[mem_address] = mem_wdata;
        end
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] v);
        mem[a]     = v;
        exp_mem[a] = v;
    endtask

    // One operation; intf_at pulses a second start mid-run, abort_at asserts reset at that cycle
    task automatic run_op(input logic md, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] fv,
                          input int intf_at, input int abort_at);
        int         exp_busy, nbytes, c, budget, busy_cnt, load_cnt, bad;
        logic [7:0] a, v;
        bit         finished;
        exp_busy = (l == 0) ? 0 : (md ? int'(l) : 3 * int'(l));
        nbytes   = (abort_at > 0) ? abort_at / 3 : int'(l);
        // Reference model: ascending, each byte read then written
        for (int k = 0; k < nbytes; k++) begin
            a = d + 8'(k);
            v = md ? fv : exp_mem[8'(s + 8'(k))];
            exp_q.push_back({a, v});
            exp_mem[a] = v;
        end
        excl_viol = 0;
        busy_cnt  = 0;
        load_cnt  = 0;
        budget    = exp_busy + 20;
        @(negedge clk);
        mode = md; src = s; dst = d; len = l; fill_value = fv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        finished = 0;
        while (!finished && c <= budget) begin
            if (busy) busy_cnt++;
            if (mem_load) load_cnt++;
            if (intf_at == c) begin
                start = 1'b1; src = s ^ 8'h45; dst = d ^ 8'h26; len = l + 8'd3;
            end else if (intf_at > 0 && intf_at + 1 == c) begin
                start = 1'b0;
            end
            if (abort_at == c) begin
                rst = 1'b1;
                #1;
                check("rst_outputs", {mem_load, mem_save, mem_address, mem_wdata, busy, done}, 0);
                finished = 1;
            end else if (done) begin
                check("done_cycle", c, exp_busy + 1);
                check("busy_cycles", busy_cnt, exp_busy);
                check("load_cycles", load_cnt, md ? 0 : int'(l));
                @(negedge clk);
                check("done_single", {busy, done, mem_load, mem_save}, 0);
                finished = 1;
            end
            if (!finished) begin
                @(negedge clk);
                c++;
            end
        end
        if (!finished) check("done_timeout", 0, 1);
        if (abort_at > 0) begin
            repeat (2) @(negedge clk);
            check("abort_quiet", {mem_load, mem_save, busy, done}, 0);
            rst = 1'b0;
            @(negedge clk);
        end
        check("pending_writes", exp_q.size(), 0);
        exp_q.delete();
        check("load_save_excl", excl_viol, 0);
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_mem[k]) bad++;
        check("mem_image", bad, 0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; excl_viol = 0;
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        src = 8'd0; dst = 8'd0; len = 8'd0; fill_value = 8'd0;
        for (int k = 0; k < 256; k++) preload(8'(k), 8'($urandom_range(0, 255)));
        #1;
        check("reset_outputs", {mem_load, mem_save, mem_address, mem_wdata, busy, done}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", {mem_load, mem_save, busy, done}, 0);

        // Basic copy
        preload(8'h10, 8'hA1); preload(8'h11, 8'hB2); preload(8'h12, 8'hC3); preload(8'h13, 8'hD4);
        run_op(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 0, 0);
        check("copy_byte0", mem[8'h80], 8'hA1);
        check("copy_byte3", mem[8'h83], 8'hD4);

        // Fill
        run_op(1'b1, 8'h00, 8'h20, 8'd3, 8'h5A, 0, 0);
        check("fill_byte2", mem[8'h22], 8'h5A);

        // Source address wrap
        preload(8'hFE, 8'h11); preload(8'hFF, 8'h22); preload(8'h00, 8'h33);
        run_op(1'b0, 8'hFE, 8'h40, 8'd3, 8'h00, 0, 0);
        check("wrap_byte2", mem[8'h42], 8'h33);

        // len = 0 no-op
        run_op(1'b0, 8'h10, 8'h50, 8'd0, 8'h00, 0, 0);
        run_op(1'b1, 8'h10, 8'h50, 8'd0, 8'h77, 0, 0);

        // start mid-copy is ignored
        run_op(1'b0, 8'h10, 8'h90, 8'd4, 8'h00, 5, 0);
        check("intf_byte1", mem[8'h91], 8'hB2);

        // Reset during the third byte's CAPTURE, then a normal copy
        run_op(1'b0, 8'h30, 8'hA0, 8'd8, 8'h00, 0, 8);
        run_op(1'b0, 8'h30, 8'hB0, 8'd5, 8'h00, 0, 0);

        // Random operations, overlap allowed
        for (int n = 0; n < 14; n++) begin
            run_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 24)), 8'($urandom_range(0, 255)), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tc_ram_copier.md
Name: tc_ram_copier

Overview:
- Bus master (initiator) for the team's 8-bit load/save RAM: the RAM responds; this block drives it.
- Performs block copy (src→dst) or block fill (constant→dst) over 8-bit address space.
- Sits between a control unit (start/busy/done) and one RAM instance; owns that RAM's load/save/address/in lines while busy.

Parameters:
- (none; data and address widths fixed at 8 to match RAM)

Ports:
- clk  input  1  system clock; RAM samples load on posedge, save on negedge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin operation when idle (sampled on posedge)
- mode  input  1  0 = copy, 1 = fill
- src  input  8  copy source base address (ignored in fill)
- dst  input  8  destination base address
- len  input  8  byte count; 0 = no-op
- fill_value  input  8  byte written in fill mode
- mem_load  output  1  to RAM load
- mem_save  output  1  to RAM save
- mem_address  output  8  to RAM address
- mem_wdata  output  8  to RAM in
- mem_rdata  input  8  from RAM out (pulls to 0 when RAM not loading)
- busy  output  1  high from cycle after accepted start until done
- done  output  1  one-cycle pulse on completion

Behaviour:
- Reset (async): state IDLE; mem_load=0, mem_save=0, mem_address=0, mem_wdata=0, busy=0, done=0; internal counters and data register cleared. Reset mid-operation aborts immediately; no further load/save; partial copy is not undone.
- All outputs are registered (driven from state/registers only); no combinational path from mem_rdata to mem_wdata.
- On start in IDLE: latch mode, src, dst, len, fill_value; clear index i=0. If len=0 → DONE next cycle (no RAM access); else → READ (copy) or WRITE (fill).
- start while not IDLE: ignored; latched operands unchanged.
- States: IDLE, READ, CAPTURE, WRITE, DONE.
- READ (copy): mem_load=1, mem_address=src+i. → CAPTURE.
- CAPTURE: mem_load=0, mem_save=0, mem_address holds src+i; RAM drives mem_rdata this cycle; data_reg <= mem_rdata at posedge ending CAPTURE. → WRITE.
- WRITE: mem_save=1, mem_address=dst+i, mem_wdata=data_reg (copy) or fill_value (fill); stable the entire cycle so RAM negedge write sees them. At end: i<=i+1; if i+1==len → DONE, else → READ (copy) or WRITE (fill).
- DONE: done=1 for exactly one cycle, busy=0, mem_load=mem_save=0. → IDLE. start in DONE is ignored.
- busy=1 in READ, CAPTURE, WRITE.
- Addresses: src+i and dst+i are 8-bit modulo 256 (wrap 0xFF→0x00). i is 8-bit; maximum len=255.
- Latency: copy = 3·len busy cycles; fill = len busy cycles; done pulses in the cycle after the final WRITE.
- Overlap: copy is strictly ascending and read-before-write per byte; overlapping regions with dst>src propagate already-copied data (documented, not corrected).
- mem_load and mem_save are never high in the same cycle.

Test Plan:
- Preload RAM[0x10..0x13]={0xA1,0xB2,0xC3,0xD4}; copy src=0x10 dst=0x80 len=4 → RAM[0x80..0x83] equal to source; busy high 12 cycles; single done pulse; RAM[0x84] unchanged.
- Fill dst=0x20 len=3 fill_value=0x5A → RAM[0x20..0x22]=0x5A; busy 3 cycles; mem_load never asserted.
- Copy src=0xFE dst=0xFF... use dst=0x40 len=3 with RAM[0xFE]=0x11, [0xFF]=0x22, [0x00]=0x33 → RAM[0x40..0x42]={0x11,0x22,0x33} (wrap).
- len=0 start → done pulse one cycle after start; no load/save; busy stays 0.
- start pulsed again mid-copy with different src/dst → ignored; original copy completes correctly.
- Assert rst during third byte's CAPTURE of len=8 copy → all outputs 0 asynchronously; only first two dst bytes written; subsequent new start runs normally.
